// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    // Canonical NOP (addi x0, x0, 0) shown to decode when nothing is buffered.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised-depth FIFO with synchronous flush; flush wins over a same-cycle push.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32 fetch stage: PC, credit-limited imem requests, wrong-path drop, decode buffer.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            decode_ready,
    output logic            instr_valid_f,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] pc_f
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0]    pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      drop_cnt;
    logic               accept;
    logic               rsp;
    logic               pop;
    logic               buf_push;
    logic [SW-1:0]      committed;
    logic [XLEN-1:0]    rsp_pc;
    logic [CW-1:0]      pcq_count;
    logic               pcq_full;
    logic               pcq_empty;
    logic [CW-1:0]      buf_count;
    logic               buf_full;
    logic               buf_empty;
    fetch_entry_t       buf_in;
    logic [ENTRY_W-1:0] buf_head_raw;
    fetch_entry_t       buf_head;
    logic               unused_ok;

    // Credit: every request in flight or word buffered holds one buffer slot.
    assign committed      = SW'(outstanding) + SW'(buf_count) - SW'(pop);
    assign imem_req_valid = rst_n & (committed < SW'(BUF_DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign rsp            = imem_rsp_valid;
    assign pop            = instr_valid_f & decode_ready;
    assign buf_push       = rsp & (drop_cnt == '0) & ~redirect_en;
    assign buf_in         = '{pc: rsp_pc, instr: imem_rsp_data};
    assign buf_head       = fetch_entry_t'(buf_head_raw);

    assign instr_valid_f  = ~buf_empty;
    assign instr_f        = buf_empty ? NOP_INSTR : buf_head.instr;
    assign pc_f           = buf_empty ? RESET_PC  : buf_head.pc;

    assign unused_ok      = &{1'b0, redirect_pc[1:0], pcq_count, pcq_full, pcq_empty, buf_full};

    // PC advances on accept; a redirect overrides it with the word-aligned target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_en) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (accept) begin
            pc <= pc + XLEN'(4);
        end
    end

    // In-flight count and number of wrong-path responses still to discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            if (redirect_en) begin
                drop_cnt <= outstanding + CW'(accept) - CW'(rsp);
            end else if (rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // PCs of requests in flight, matched to in-order responses.
    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (accept),
        .wdata (pc),
        .pop   (rsp),
        .rdata (rsp_pc),
        .count (pcq_count),
        .full  (pcq_full),
        .empty (pcq_empty)
    );

    // Instruction buffer towards decode, cleared by a redirect.
    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_instr_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_en),
        .push  (buf_push),
        .wdata (buf_in),
        .pop   (pop),
        .rdata (buf_head_raw),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench: depth-2 instance on 1-cycle memory, depth-4 instance on 3-cycle memory.
module tb_fetch_stage;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr_a,  req_addr_b;
    logic        rdy_a = 1'b1, rdy_b = 1'b1;
    logic        rsp_valid_a = 1'b0, rsp_valid_b = 1'b0;
    logic [31:0] rsp_data_a = '0, rsp_data_b = '0;
    logic        redir_a = 1'b0, redir_b = 1'b0;
    logic [31:0] rpc_a = '0, rpc_b = '0;
    logic        dr_a = 1'b1, dr_b = 1'b1;
    logic        ivalid_a, ivalid_b;
    logic [31:0] instr_a, instr_b;
    logic [31:0] pcf_a, pcf_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid_a), .imem_req_ready(rdy_a), .imem_req_addr(req_addr_a),
        .imem_rsp_valid(rsp_valid_a), .imem_rsp_data(rsp_data_a),
        .redirect_en(redir_a), .redirect_pc(rpc_a), .decode_ready(dr_a),
        .instr_valid_f(ivalid_a), .instr_f(instr_a), .pc_f(pcf_a)
    );

    fetch_stage #(.RESET_PC(32'h0), .BUF_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid_b), .imem_req_ready(rdy_b), .imem_req_addr(req_addr_b),
        .imem_rsp_valid(rsp_valid_b), .imem_rsp_data(rsp_data_b),
        .redirect_en(redir_b), .redirect_pc(rpc_b), .decode_ready(dr_b),
        .instr_valid_f(ivalid_b), .instr_f(instr_b), .pc_f(pcf_b)
    );

    // Memory A: in-order, fixed latency, word at address a is ~a.
    logic [31:0] qa_addr[$];
    int          qa_due[$];
    int          cyc_a = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            qa_addr.delete(); qa_due.delete(); cyc_a = 0;
            rsp_valid_a <= 1'b0; rsp_data_a <= '0;
        end else begin
            cyc_a++;
            if (req_valid_a && rdy_a) begin
                qa_addr.push_back(req_addr_a); qa_due.push_back(cyc_a + LAT_A);
            end
            if (qa_due.size() > 0 && qa_due[0] == cyc_a + 1) begin
                rsp_valid_a <= 1'b1; rsp_data_a <= ~qa_addr[0];
                void'(qa_addr.pop_front()); void'(qa_due.pop_front());
            end else begin
                rsp_valid_a <= 1'b0; rsp_data_a <= '0;
            end
        end
    end

    // Memory B: same model with a longer latency.
    logic [31:0] qb_addr[$];
    int          qb_due[$];
    int          cyc_b = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            qb_addr.delete(); qb_due.delete(); cyc_b = 0;
            rsp_valid_b <= 1'b0; rsp_data_b <= '0;
        end else begin
            cyc_b++;
            if (req_valid_b && rdy_b) begin
                qb_addr.push_back(req_addr_b); qb_due.push_back(cyc_b + LAT_B);
            end
            if (qb_due.size() > 0 && qb_due[0] == cyc_b + 1) begin
                rsp_valid_b <= 1'b1; rsp_data_b <= ~qb_addr[0];
                void'(qb_addr.pop_front()); void'(qb_due.pop_front());
            end else begin
                rsp_valid_b <= 1'b0; rsp_data_b <= '0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset with memory ready and decode ready.
        repeat (3) @(negedge clk);
        check_eq("rst_req_valid",   32'(req_valid_a), 32'h0);
        check_eq("rst_req_addr",    req_addr_a,       32'h0);
        check_eq("rst_instr_valid", 32'(ivalid_a),    32'h0);
        check_eq("rst_instr",       instr_a,          32'h0000_0013);
        check_eq("rst_pc_f",        pcf_a,            32'h0);

        rst_n = 1'b1;
        #1;
        check_eq("first_req_valid", 32'(req_valid_a), 32'h1);
        check_eq("first_req_addr",  req_addr_a,       32'h0);
        @(negedge clk);
        check_eq("req_addr_4",      req_addr_a,       32'h4);
        check_eq("no_instr_yet",    32'(ivalid_a),    32'h0);
        @(negedge clk);
        check_eq("req_addr_8",      req_addr_a,       32'h8);
        check_eq("stream_valid0",   32'(ivalid_a),    32'h1);
        check_eq("stream_pc0",      pcf_a,            32'h0);
        check_eq("stream_instr0",   instr_a,          ~32'h0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check_eq("stream_valid", 32'(ivalid_a), 32'h1);
            check_eq("stream_pc",    pcf_a,         32'(4 * i));
        end
        check_eq("stream_req_addr", req_addr_a, 32'h14);

        // Backpressure: decode stalls with head 0xC and 0x10 still in flight.
        dr_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_req_valid", 32'(req_valid_a), 32'h0);
            check_eq("bp_head_pc",   pcf_a,            32'hC);
        end
        check_eq("bp_addr_hold", req_addr_a, 32'h14);
        dr_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bp_release_pc",    pcf_a,   32'(32'h10 + 4 * i));
            check_eq("bp_release_instr", instr_a, ~(32'(32'h10 + 4 * i)));
        end

        // Coincident redirect: response 0x20 and accept of 0x24 in the same cycle.
        check_eq("coinc_pre_addr", req_addr_a, 32'h24);
        redir_a = 1'b1; rpc_a = 32'h800;
        @(negedge clk);
        redir_a = 1'b0;
        check_eq("coinc_addr",   req_addr_a,    32'h800);
        check_eq("coinc_flush",  32'(ivalid_a), 32'h0);
        @(negedge clk);
        check_eq("coinc_drop",   32'(ivalid_a), 32'h0);
        check_eq("coinc_addr2",  req_addr_a,    32'h804);
        @(negedge clk);
        check_eq("coinc_pc",     pcf_a,         32'h800);
        check_eq("coinc_instr",  instr_a,       ~32'h800);

        // Back-to-back redirects: 0x200 then 0x300 on the next cycle.
        redir_a = 1'b1; rpc_a = 32'h200;
        @(negedge clk);
        check_eq("b2b_addr1",  req_addr_a,    32'h200);
        check_eq("b2b_flush1", 32'(ivalid_a), 32'h0);
        rpc_a = 32'h300;
        @(negedge clk);
        redir_a = 1'b0;
        check_eq("b2b_addr2",  req_addr_a,    32'h300);
        check_eq("b2b_flush2", 32'(ivalid_a), 32'h0);
        @(negedge clk);
        check_eq("b2b_drop",   32'(ivalid_a), 32'h0);
        check_eq("b2b_addr3",  req_addr_a,    32'h304);
        @(negedge clk);
        check_eq("b2b_pc0",    pcf_a,         32'h300);
        @(negedge clk);
        check_eq("b2b_pc1",    pcf_a,         32'h304);

        // PC wrap from the top word of the address space.
        redir_a = 1'b1; rpc_a = 32'hFFFF_FFFC;
        @(negedge clk);
        redir_a = 1'b0;
        check_eq("wrap_addr_top", req_addr_a, 32'hFFFF_FFFC);
        @(negedge clk);
        check_eq("wrap_addr_0",   req_addr_a, 32'h0);
        @(negedge clk);
        check_eq("wrap_pc_top",   pcf_a,      32'hFFFF_FFFC);
        check_eq("wrap_instr",    instr_a,    32'h0000_0003);
        @(negedge clk);
        check_eq("wrap_pc_0",     pcf_a,      32'h0);

        // Redirect with three requests in flight on the 3-cycle memory.
        check_eq("flight_pre_valid", 32'(ivalid_b), 32'h1);
        redir_b = 1'b1; rpc_b = 32'h1003;
        @(negedge clk);
        redir_b = 1'b0;
        check_eq("flight_addr", req_addr_b, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check_eq("flight_drop", 32'(ivalid_b), 32'h0);
        end
        @(negedge clk);
        check_eq("flight_pc0",    pcf_b,   32'h1000);
        check_eq("flight_instr0", instr_b, ~32'h1000);
        @(negedge clk);
        check_eq("flight_pc1",    pcf_b,   32'h1004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32 pipeline: owns the program counter, issues word-aligned requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses, and presents `{pc, instr}` pairs to the decode stage through a small flushable buffer. It is the producer for decode's `instr`/`pc_d_in` inputs. It accepts a branch/jump redirect from execute, discarding wrong-path responses already in flight.

## Interface
- `RESET_PC`, `32'h0000_0000`: PC of the first fetch after reset.
- `BUF_DEPTH`, `2`: instruction buffer entries; also the maximum number of outstanding requests. Full throughput needs memory latency plus 1 or more. Minimum 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  byte address; bits [1:0] always 0.
- `imem_rsp_valid`  in  1  response valid. There is no backpressure; responses return in request order.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_en`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  target; bits [1:0] are ignored and treated as 0.
- `decode_ready`  in  1  decode consumes the buffer head this cycle.
- `instr_valid_f`  out  1  buffer head valid.
- `instr_f`  out  32  head instruction; `32'h0000_0013` (NOP) when empty.
- `pc_f`  out  32  head PC.

## Operation
- **Credit rule:** `imem_req_valid = (outstanding + buf_count − pop) < BUF_DEPTH`.
  - `pop = instr_valid_f & decode_ready`.
  - `outstanding` counts accepted requests without a response, including requests marked for drop.
  - This guarantees buffer space for every response.
- **Request accept** (`imem_req_valid & imem_req_ready`):
  - Push `imem_req_addr` into the request-PC queue.
  - `pc <= pc + 4`, wrapping modulo 2^32.
  - `outstanding++`.
- **Response:**
  - `outstanding--`.
  - Pop the request-PC queue.
  - If `drop_cnt > 0`: discard the word and decrement `drop_cnt`.
  - Otherwise push `{pc, data}` into the instruction buffer.
- **Redirect:**
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - The instruction buffer is cleared, including any same-cycle push.
  - `drop_cnt <= outstanding + accept − rsp`, where `rsp` is a response arriving this cycle. That response is dropped itself, and the request-PC queue advances normally.
  - A request accepted in the redirect cycle used the old PC and is dropped.
- **Pop on redirect:** a pop in the redirect cycle is legal and has no further effect.
- **Redirect during drop:** `drop_cnt` is recomputed from `outstanding`, so the sequence is correct.
- **Request hold:** `imem_req_valid` and `imem_req_addr` stay stable until accepted. The one exception is that the address changes in the cycle after a redirect.
- **Simultaneous push and pop** on a full buffer is legal: the count is unchanged.

## Timing
- **During reset:**
  - `imem_req_valid=0` and `imem_req_addr=RESET_PC`.
  - `instr_valid_f=0`, `instr_f=32'h0000_0013`, `pc_f=RESET_PC`.
  - All counters and queues are 0.
- **First request:** the first rising edge after `rst_n` deasserts sees `imem_req_valid=1`.
- **Reset mid-operation:** state returns to reset values immediately. Memory responses arriving after reset release, for pre-reset requests, are outside the contract; memory is reset together with this block.
- **Latency:**
  - A response in cycle N appears on `instr_valid_f` in cycle N+1 (registered buffer, no bypass).
  - A redirect in cycle N gives `imem_req_addr = target` in cycle N+1 and `instr_valid_f=0` in cycle N+1.
- **Throughput:** 1 instruction per cycle with 1-cycle memory and `BUF_DEPTH=2`.

## Structure
- Shared package `fetch_pkg`: `NOP_INSTR = 32'h0000_0013`, the `fetch_entry_t` struct `{logic [31:0] pc; logic [31:0] instr;}`, and the `XLEN = 32` constant.
- Sub-module `fetch_fifo`: a parameterised-depth FIFO with synchronous flush, with count, full and empty outputs. It is instantiated twice:
  - as the request-PC queue, never flushed;
  - as the instruction buffer, flushed on redirect.
- The top level holds the PC register, `outstanding` and `drop_cnt` counters, and credit logic.

## Test plan
- **Reset:** hold `rst_n=0` with `imem_req_ready=1`, then release → `imem_req_valid=0` while in reset. After release, requests go out to 0x0, 0x4, 0x8 on consecutive cycles. With 1-cycle memory, `instr_valid_f` is high every cycle from cycle 3, with `pc_f` 0x0, 0x4, ….
- **Backpressure:** `decode_ready=0` for 5 cycles → at most 2 requests outstanding or buffered, and `imem_req_valid=0` thereafter. Releasing gives the PCs in order with none lost or duplicated.
- **Redirect with flight:** 3-cycle memory, `BUF_DEPTH=4`, with `redirect_en=1` and `redirect_pc=0x1003` while 3 requests are in flight → the next address is 0x1000. The 3 stale responses are dropped, and the first valid output is `pc_f=0x1000`.
- **Coincident redirect:** a redirect in the same cycle as a response and a request accept → both words are dropped, and the first post-redirect output carries the target PC.
- **Back-to-back redirects:** two redirects 1 cycle apart, to 0x200 then 0x300 → no 0x200-path instruction ever appears on the output.
- **PC wrap:** `redirect_pc=0xFFFF_FFFC` → the following request address is 0x0000_0000.
